line_buffer_kxk: RTL and testbench

Parametrised sliding-window generator: accepts a raster-scan pixel stream and emits every KERNEL_SIZE×KERNEL_SIZE window at a configurable stride. It sits between the feature-map source and the convolution engines (traditional or sparse PE array). It generalises the fixed 5×5 line buffer to arbitrary kernel size, rectangular images and stride. It adds ready/valid back-pressure on both sides and a frame-done marker.

---
 rtl/line_buffer_pkg.sv | 13 +
 rtl/lb_row_delay.sv | 24 ++
 rtl/line_buffer_kxk.sv | 137 +++++++++++++
 tb/tb_line_buffer_kxk.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buffer_pkg.sv
// Shared constants and window packing helper for the KxK line buffer.
package line_buffer_pkg;

  localparam int DEFAULT_WORD_LENGTH = 8;
  localparam int DEFAULT_KERNEL_SIZE = 5;
  localparam int COORD_W             = 16;

  // Bit offset of window element (i,j); row 0 oldest, col 0 leftmost.
  function automatic int win_offset(input int i, input int j, input int k, input int w);
    return (i * k + j) * w;
  endfunction

endpackage

// File: rtl/lb_row_delay.sv
// One image row of pixel delay: dout is the pixel accepted DEPTH enables ago.
module lb_row_delay #(
  parameter int WORD_LENGTH = 8,
  parameter int DEPTH       = 36
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic [WORD_LENGTH-1:0] din,
  output logic [WORD_LENGTH-1:0] dout
);

  logic [WORD_LENGTH-1:0] mem [DEPTH];

  // No reset: stale contents are never emitted because the counters gate output.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/line_buffer_kxk.sv
// Sliding KxK window generator over a raster pixel stream with ready/valid on both sides.
// Optional LINE_BUFFER_POS_EN adds out_row/out_col (window top-left coordinate).
module line_buffer_kxk
  import line_buffer_pkg::*;
#(
  parameter int WORD_LENGTH  = DEFAULT_WORD_LENGTH,
  parameter int KERNEL_SIZE  = DEFAULT_KERNEL_SIZE,
  parameter int IMAGE_WIDTH  = 36,
  parameter int IMAGE_HEIGHT = 36,
  parameter int STRIDE       = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [WORD_LENGTH-1:0]                    data_in,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*WORD_LENGTH-1:0] window_out,
  output logic                                      frame_done
`ifdef LINE_BUFFER_POS_EN
  ,
  output logic [COORD_W-1:0]                        out_row,
  output logic [COORD_W-1:0]                        out_col
`endif
);

  localparam int K    = KERNEL_SIZE;
  localparam int WW   = K * K * WORD_LENGTH;
  localparam int PH_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [COORD_W-1:0] K1       = COORD_W'(K - 1);
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMAGE_WIDTH - 1);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMAGE_HEIGHT - 1);
  localparam logic [PH_W-1:0]    PH_LAST  = PH_W'(STRIDE - 1);

  logic                   accept, complete, col_last, row_last;
  logic [COORD_W-1:0]     col_cnt, row_cnt;
  logic [PH_W-1:0]        col_ph, row_ph;
  logic [WORD_LENGTH-1:0] tap     [K-1];
  logic [WORD_LENGTH-1:0] col_in  [K];
  logic [WORD_LENGTH-1:0] win     [K][K];
  logic [WORD_LENGTH-1:0] win_next[K][K];
  logic [WW-1:0]          win_flat;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col_cnt == COL_LAST);
  assign row_last = (row_cnt == ROW_LAST);
  assign complete = accept && (row_cnt >= K1) && (col_cnt >= K1) &&
                    (row_ph == '0) && (col_ph == '0);

  // Delay lines are chained: tap[m] is the pixel m+1 rows above data_in.
  for (genvar g = 0; g < K - 1; g++) begin : g_line
    if (g == 0) begin : g_first
      lb_row_delay #(.WORD_LENGTH(WORD_LENGTH), .DEPTH(IMAGE_WIDTH)) u_line (
        .clk(clk), .en(accept), .din(data_in), .dout(tap[g]));
    end else begin : g_next
      lb_row_delay #(.WORD_LENGTH(WORD_LENGTH), .DEPTH(IMAGE_WIDTH)) u_line (
        .clk(clk), .en(accept), .din(tap[g-1]), .dout(tap[g]));
    end
  end

  always_comb begin
    col_in[K-1] = data_in;
    for (int m = 0; m < K - 1; m++) col_in[K-2-m] = tap[m];
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) win_next[i][j] = win[i][j+1];
      win_next[i][K-1] = col_in[i];
    end
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        win_flat[win_offset(i, j, K, WORD_LENGTH) +: WORD_LENGTH] = win_next[i][j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win[i][j] <= '0;
    end else if (accept) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win[i][j] <= win_next[i][j];
    end
  end

  // Phases stay 0 until the first full-window row/column, then count modulo STRIDE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
      col_ph  <= '0;
      row_ph  <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_cnt <= '0;
        col_ph  <= '0;
        if (row_last) begin
          row_cnt <= '0;
          row_ph  <= '0;
        end else begin
          row_cnt <= row_cnt + COORD_W'(1);
          if (row_cnt >= K1) row_ph <= (row_ph == PH_LAST) ? '0 : row_ph + PH_W'(1);
        end
      end else begin
        col_cnt <= col_cnt + COORD_W'(1);
        if (col_cnt >= K1) col_ph <= (col_ph == PH_LAST) ? '0 : col_ph + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      window_out <= '0;
`ifdef LINE_BUFFER_POS_EN
      out_row    <= '0;
      out_col    <= '0;
`endif
    end else if (complete) begin
      out_valid  <= 1'b1;
      frame_done <= row_last && col_last;
      window_out <= win_flat;
`ifdef LINE_BUFFER_POS_EN
      out_row    <= row_cnt - K1;
      out_col    <= col_cnt - K1;
`endif
    end else if (out_ready) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_buffer_kxk.sv
// Scoreboard bench: stride-1 and stride-2 instances fed the same accepted pixel stream.
module tb_line_buffer_kxk;

  localparam int W  = 8;
  localparam int K  = 5;
  localparam int IW = 36;
  localparam int IH = 36;
  localparam int WW = K * K * W;

  typedef struct {
    logic [WW-1:0] win;
    logic          fd;
    int            r;
    int            c;
  } exp_t;

  logic clk, rst_n, in_valid, out_ready;
  logic [W-1:0] data_in;
  logic in_ready, out_valid, frame_done;
  logic [WW-1:0] window_out;
  logic in_valid2, in_ready2, out_valid2, frame_done2;
  logic [WW-1:0] window_out2;
`ifdef LINE_BUFFER_POS_EN
  logic [15:0] out_row, out_col, out_row2, out_col2;
`endif

  assign in_valid2 = in_valid && in_ready;

  line_buffer_kxk #(.WORD_LENGTH(W), .KERNEL_SIZE(K), .IMAGE_WIDTH(IW),
                    .IMAGE_HEIGHT(IH), .STRIDE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .window_out(window_out), .frame_done(frame_done)
`ifdef LINE_BUFFER_POS_EN
    , .out_row(out_row), .out_col(out_col)
`endif
  );

  line_buffer_kxk #(.WORD_LENGTH(W), .KERNEL_SIZE(K), .IMAGE_WIDTH(IW),
                    .IMAGE_HEIGHT(IH), .STRIDE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .data_in(data_in), .out_valid(out_valid2), .out_ready(1'b1),
    .window_out(window_out2), .frame_done(frame_done2)
`ifdef LINE_BUFFER_POS_EN
    , .out_row(out_row2), .out_col(out_col2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference model: current frame image plus the window selection rule.
  logic [W-1:0] pix [IH][IW];
  int m_r = 0, m_c = 0, acc_total = 0;
  exp_t q1[$], q2[$];
  int n_win1 = 0, n_win2 = 0, fd_cnt1 = 0;
  int fd_idx1 [16];
  int log1_a00 [8192], log1_a44 [8192], log1_acc [8192], log2_a00 [8192];
  bit pend1 = 0, stall_prev = 0;
  logic [WW-1:0] st_win;
  logic st_fd;

  function automatic exp_t make_exp(input int r, input int c);
    exp_t e;
    e.win = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        e.win[(i*K+j)*W +: W] = pix[r-K+1+i][c-K+1+j];
    e.fd = (r == IH-1) && (c == IW-1);
    e.r  = r - K + 1;
    e.c  = c - K + 1;
    return e;
  endfunction

  function automatic bit selects(input int r, input int c, input int s);
    return (r >= K-1) && (c >= K-1) && ((r-K+1) % s == 0) && ((c-K+1) % s == 0);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q1.delete(); q2.delete();
      m_r = 0; m_c = 0; pend1 = 0; stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_window", window_out, st_win);
        chk("stall_frame_done", frame_done, st_fd);
      end
      stall_prev = out_valid && !out_ready;
      if (stall_prev) begin
        st_win = window_out; st_fd = frame_done;
        chk("stall_in_ready", in_ready, 1'b0);
      end
      if (pend1) chk("latency_out_valid", out_valid, 1'b1);
      pend1 = 0;

      if (out_valid && out_ready) begin
        if (q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb1_unexpected: got window %0h required none", window_out);
        end else begin
          e = q1.pop_front();
          chk("sb1_window", window_out, e.win);
          chk("sb1_frame_done", frame_done, e.fd);
`ifdef LINE_BUFFER_POS_EN
          chk("sb1_row", out_row, 16'(e.r));
          chk("sb1_col", out_col, 16'(e.c));
`endif
        end
        if (n_win1 < 8192) begin
          log1_a00[n_win1] = int'(window_out[W-1:0]);
          log1_a44[n_win1] = int'(window_out[(4*K+4)*W +: W]);
          log1_acc[n_win1] = acc_total;
        end
        if (frame_done) begin
          if (fd_cnt1 < 16) fd_idx1[fd_cnt1] = n_win1;
          fd_cnt1++;
        end
        n_win1++;
      end

      if (out_valid2) begin
        if (q2.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb2_unexpected: got window %0h required none", window_out2);
        end else begin
          e = q2.pop_front();
          chk("sb2_window", window_out2, e.win);
          chk("sb2_frame_done", frame_done2, e.fd);
`ifdef LINE_BUFFER_POS_EN
          chk("sb2_row", out_row2, 16'(e.r));
          chk("sb2_col", out_col2, 16'(e.c));
`endif
        end
        if (n_win2 < 8192) log2_a00[n_win2] = int'(window_out2[W-1:0]);
        n_win2++;
      end

      if (in_valid && in_ready) begin
        pix[m_r][m_c] = data_in;
        if (selects(m_r, m_c, 1)) begin q1.push_back(make_exp(m_r, m_c)); pend1 = 1; end
        if (selects(m_r, m_c, 2)) q2.push_back(make_exp(m_r, m_c));
        acc_total++;
        m_c++;
        if (m_c == IW) begin m_c = 0; m_r++; if (m_r == IH) m_r = 0; end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input bit rnd);
    bit acc;
    int t;
    if (rnd && $urandom_range(0, 4) == 0) begin
      in_valid = 1'b0; @(posedge clk); #1;
    end
    in_valid = 1'b1; data_in = d; t = 0;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      t++;
    end while (!acc && t < 100);
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got no accept in %0d cycles required accept", t);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  int b1, b2, a0, fdb;
  bit held;
  logic [WW-1:0] hw;

  initial begin
    in_valid = 1'b0; data_in = '0; out_ready = 1'b1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_frame_done", frame_done, 1'b0);
    chk("reset_window", window_out, '0);
    chk("reset_in_ready", in_ready, 1'b1);
`ifdef LINE_BUFFER_POS_EN
    chk("reset_out_row", out_row, 16'd0);
    chk("reset_out_col", out_col, 16'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp frame, full throughput
    b1 = n_win1; b2 = n_win2; a0 = acc_total;
    for (int i = 0; i < IW*IH; i++) send(W'(i+1), 1'b0);
    drain();
    chk("ramp_count", n_win1 - b1, 1024);
    chk("ramp_first_acc", log1_acc[b1], a0 + 149);
    chk("ramp_first_00", log1_a00[b1], 1);
    chk("ramp_first_44", log1_a44[b1], 149);
    chk("ramp_second_00", log1_a00[b1+1], 2);
    chk("rowwrap_last_acc", log1_acc[b1+31], a0 + 180);
    chk("rowwrap_next_acc", log1_acc[b1+32], a0 + 185);
    chk("rowwrap_next_00", log1_a00[b1+32], 37);
    chk("s2_count", n_win2 - b2, 256);
    chk("s2_first_00", log2_a00[b2], 1);
    chk("s2_second_00", log2_a00[b2+1], 3);
    chk("s2_row1_00", log2_a00[b2+16], 73);

    // Random data with idle gaps, random back-pressure and one 3-cycle hold
    b1 = n_win1; b2 = n_win2; held = 0;
    for (int i = 0; i < IW*IH; i++) begin
      send(W'($urandom), 1'b1);
      if (!held && i >= 300 && out_valid) begin
        held = 1; out_ready = 1'b0; hw = window_out;
        repeat (3) begin
          @(posedge clk); #1;
          chk("hold_in_ready", in_ready, 1'b0);
          chk("hold_valid", out_valid, 1'b1);
          chk("hold_window", window_out, hw);
        end
        out_ready = 1'b1;
      end
    end
    drain();
    chk("bp_hold_done", held, 1'b1);
    chk("bp_count", n_win1 - b1, 1024);
    chk("bp_s2_count", n_win2 - b2, 256);

    // Reset mid-frame, then a fresh ramp frame
    for (int i = 0; i < 500; i++) send(W'(i+1), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_valid2", out_valid2, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    b1 = n_win1; a0 = acc_total;
    for (int i = 0; i < IW*IH; i++) send(W'(i+1), 1'b0);
    drain();
    chk("postrst_count", n_win1 - b1, 1024);
    chk("postrst_first_acc", log1_acc[b1], a0 + 149);
    chk("postrst_first_00", log1_a00[b1], 1);

    // Two back-to-back frames
    b1 = n_win1; b2 = n_win2; fdb = fd_cnt1;
    for (int i = 0; i < 2*IW*IH; i++) send(W'($urandom), 1'b0);
    drain();
    chk("b2b_count", n_win1 - b1, 2048);
    chk("b2b_s2_count", n_win2 - b2, 512);
    chk("b2b_fd_count", fd_cnt1 - fdb, 2);
    chk("b2b_fd_first", fd_idx1[fdb], b1 + 1023);
    chk("b2b_fd_second", fd_idx1[fdb+1], b1 + 2047);

    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion required completion");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
